// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//
// Raster sequencer that sits in front of the Mandelbrot engine. A frame
// start latches the view parameters and then walks every pixel in raster
// order. Each pixel gets one request/release handshake with the engine,
// and the returned iteration count is written to the framebuffer port,
// which may apply backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          frame start (level sampled), synchronous abort
//   *_in                  view parameters, sampled on frame start
//   center_x/center_y/zoom_level/max_iter_limit
//                         latched view parameters presented to the engine
//   pixel_x/pixel_y       current pixel coordinates presented to the engine
//   pixel_valid           engine request
//   eng_result_valid/eng_iteration_count/eng_busy
//                         engine result handshake and idle indication
//   wr_valid/wr_addr/wr_data/wr_ready
//                         framebuffer write port (valid/ready)
//   frame_busy            frame in progress (decoded from state)
//   frame_done            one-cycle pulse after the last pixel is written

module pixel_scheduler #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           center_x_in,
  input  logic [15:0]           center_y_in,
  input  logic [7:0]            zoom_in,
  input  logic [ITER_WIDTH-1:0] max_iter_in,
  output logic [15:0]           center_x,
  output logic [15:0]           center_y,
  output logic [7:0]            zoom_level,
  output logic [ITER_WIDTH-1:0] max_iter_limit,
  output logic [9:0]            pixel_x,
  output logic [9:0]            pixel_y,
  output logic                  pixel_valid,
  input  logic                  eng_result_valid,
  input  logic [ITER_WIDTH-1:0] eng_iteration_count,
  input  logic                  eng_busy,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ITER_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  frame_busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    WRITE
  } state_t;

  localparam logic [9:0]            X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]            Y_LAST   = 10'(V_RES - 1);
  localparam logic [9:0]            COORD_ONE = 10'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state, state_next;
  logic [15:0]             center_x_next, center_y_next;
  logic [7:0]              zoom_level_next;
  logic [ITER_WIDTH-1:0]   max_iter_limit_next;
  logic [9:0]              pixel_x_next, pixel_y_next;
  logic                    pixel_valid_next;
  logic                    wr_valid_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_next;
  logic [ITER_WIDTH-1:0]   wr_data_next;
  logic                    frame_done_next;

  assign frame_busy = (state != IDLE);

  // State and every registered output. wr_addr doubles as the linear
  // address counter, so it tracks y*H_RES+x by incrementing rather than
  // multiplying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      center_x       <= '0;
      center_y       <= '0;
      zoom_level     <= '0;
      max_iter_limit <= '0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      pixel_valid    <= 1'b0;
      wr_valid       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_next;
      center_x       <= center_x_next;
      center_y       <= center_y_next;
      zoom_level     <= zoom_level_next;
      max_iter_limit <= max_iter_limit_next;
      pixel_x        <= pixel_x_next;
      pixel_y        <= pixel_y_next;
      pixel_valid    <= pixel_valid_next;
      wr_valid       <= wr_valid_next;
      wr_addr        <= wr_addr_next;
      wr_data        <= wr_data_next;
      frame_done     <= frame_done_next;
    end
  end

  // Next-state and next-output logic. Abort overrides everything: the
  // request and any pending write are dropped, but the latched view
  // parameters are kept. A start that arrives while the engine is still
  // busy is simply ignored.
  always_comb begin
    state_next          = state;
    center_x_next       = center_x;
    center_y_next       = center_y;
    zoom_level_next     = zoom_level;
    max_iter_limit_next = max_iter_limit;
    pixel_x_next        = pixel_x;
    pixel_y_next        = pixel_y;
    pixel_valid_next    = pixel_valid;
    wr_valid_next       = wr_valid;
    wr_addr_next        = wr_addr;
    wr_data_next        = wr_data;
    frame_done_next     = 1'b0;

    if (abort) begin
      state_next       = IDLE;
      pixel_valid_next = 1'b0;
      wr_valid_next    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !eng_busy) begin
            center_x_next       = center_x_in;
            center_y_next       = center_y_in;
            zoom_level_next     = zoom_in;
            max_iter_limit_next = max_iter_in;
            pixel_x_next        = '0;
            pixel_y_next        = '0;
            wr_addr_next        = '0;
            pixel_valid_next    = 1'b1;
            state_next          = ISSUE;
          end
        end

        ISSUE: begin
          if (eng_result_valid) begin
            wr_data_next     = eng_iteration_count;
            pixel_valid_next = 1'b0;
            state_next       = RELEASE;
          end
        end

        RELEASE: begin
          if (!eng_busy) begin
            wr_valid_next = 1'b1;
            state_next    = WRITE;
          end
        end

        WRITE: begin
          if (wr_ready) begin
            wr_valid_next = 1'b0;
            if (pixel_x == X_LAST && pixel_y == Y_LAST) begin
              frame_done_next = 1'b1;
              state_next      = IDLE;
            end else begin
              if (pixel_x == X_LAST) begin
                pixel_x_next = '0;
                pixel_y_next = pixel_y + COORD_ONE;
              end else begin
                pixel_x_next = pixel_x + COORD_ONE;
              end
              wr_addr_next     = wr_addr + ADDR_ONE;
              pixel_valid_next = 1'b1;
              state_next       = ISSUE;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler
//
// Directed bench for pixel_scheduler on a 4x3 frame. A behavioural engine
// answers each request with (x+2y)%64 after a programmable latency and
// holds its result until the request is released. A write monitor checks
// every accepted framebuffer write against the expected address sequence
// and data, and checks that frame_done pulses exactly in the cycle after
// the last pixel is accepted.

module tb_pixel_scheduler;

  localparam int H_RES      = 4;
  localparam int V_RES      = 3;
  localparam int ADDR_WIDTH = 4;
  localparam int ITER_WIDTH = 6;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic [15:0]           center_x_in;
  logic [15:0]           center_y_in;
  logic [7:0]            zoom_in;
  logic [ITER_WIDTH-1:0] max_iter_in;
  logic [15:0]           center_x;
  logic [15:0]           center_y;
  logic [7:0]            zoom_level;
  logic [ITER_WIDTH-1:0] max_iter_limit;
  logic [9:0]            pixel_x;
  logic [9:0]            pixel_y;
  logic                  pixel_valid;
  logic                  eng_result_valid;
  logic [ITER_WIDTH-1:0] eng_iteration_count;
  logic                  eng_busy;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ITER_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  frame_busy;
  logic                  frame_done;

  int checks      = 0;
  int failures    = 0;
  int exp_addr    = 0;
  int write_count = 0;
  int pulse_count = 0;
  logic done_due  = 1'b0;
  logic slow_en   = 1'b0;

  pixel_scheduler #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ITER_WIDTH(ITER_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .center_x_in(center_x_in),
    .center_y_in(center_y_in),
    .zoom_in(zoom_in),
    .max_iter_in(max_iter_in),
    .center_x(center_x),
    .center_y(center_y),
    .zoom_level(zoom_level),
    .max_iter_limit(max_iter_limit),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_valid(pixel_valid),
    .eng_result_valid(eng_result_valid),
    .eng_iteration_count(eng_iteration_count),
    .eng_busy(eng_busy),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .frame_busy(frame_busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expData(input int a);
    return 32'(((a % H_RES) + 2 * (a / H_RES)) % 64);
  endfunction

  // Step to just after the next rising edge, clear of the engine model.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present view parameters and hold start for one cycle.
  task automatic applyStimulus(input logic [15:0] cx, input logic [15:0] cy,
                               input logic [7:0] zm, input logic [ITER_WIDTH-1:0] mi);
    center_x_in = cx;
    center_y_in = cy;
    zoom_in     = zm;
    max_iter_in = mi;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 600) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(frame_done), 32'd1);
  endtask

  // Behavioural engine: accept a request, compute for a latency, hold the
  // result until the request drops, then go idle one cycle later.
  typedef enum {M_IDLE, M_CALC, M_HOLD, M_DRAIN} mstate_t;
  mstate_t m_state;
  int m_x, m_y, m_cnt;

  initial begin
    m_state             = M_IDLE;
    eng_busy            = 1'b0;
    eng_result_valid    = 1'b0;
    eng_iteration_count = '0;
    m_x = 0;
    m_y = 0;
    m_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_state          = M_IDLE;
        eng_busy         = 1'b0;
        eng_result_valid = 1'b0;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (pixel_valid) begin
              m_x      = int'(pixel_x);
              m_y      = int'(pixel_y);
              eng_busy = 1'b1;
              m_cnt    = (slow_en && m_x == 3 && m_y == 0) ? 40 : 3;
              m_state  = M_CALC;
            end
          end
          M_CALC: begin
            if (m_cnt > 1) begin
              m_cnt--;
            end else begin
              eng_result_valid    = 1'b1;
              eng_iteration_count = ITER_WIDTH'((m_x + 2 * m_y) % 64);
              m_state             = M_HOLD;
            end
          end
          M_HOLD: begin
            if (!pixel_valid) begin
              eng_result_valid = 1'b0;
              m_state          = M_DRAIN;
            end
          end
          M_DRAIN: begin
            eng_busy = 1'b0;
            m_state  = M_IDLE;
          end
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  // Write and frame_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_due = 1'b0;
    end else begin
      if (frame_done || done_due)
        checkOutput("frame_done_pulse", 32'(frame_done), 32'(done_due));
      if (frame_done)
        pulse_count++;
      done_due = 1'b0;
      if (wr_valid && wr_ready && !abort) begin
        checkOutput("wr_addr_seq", 32'(wr_addr), 32'(exp_addr));
        checkOutput("wr_data_val", 32'(wr_data), expData(exp_addr));
        done_due = (exp_addr == H_RES * V_RES - 1);
        exp_addr++;
        write_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    center_x_in = '0;
    center_y_in = '0;
    zoom_in     = '0;
    max_iter_in = '0;
    wr_ready    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();

    // Reset state.
    checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_frame_busy", 32'(frame_busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_center_x", 32'(center_x), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame A: plain frame; center_x_in changes mid-frame.
    exp_addr = 0; write_count = 0; pulse_count = 0;
    applyStimulus(16'h1000, 16'hF800, 8'h05, 6'd63);
    checkOutput("a_frame_busy", 32'(frame_busy), 32'd1);
    checkOutput("a_pixel_valid", 32'(pixel_valid), 32'd1);
    checkOutput("a_center_y", 32'(center_y), 32'h0000F800);
    checkOutput("a_zoom", 32'(zoom_level), 32'h05);
    checkOutput("a_max_iter", 32'(max_iter_limit), 32'd63);
    repeat (20) tick();
    center_x_in = 16'h2000;
    repeat (20) tick();
    checkOutput("a_center_x_mid", 32'(center_x), 32'h1000);
    waitFrameDone("a_frame_done_seen");
    checkOutput("a_center_x_done", 32'(center_x), 32'h1000);
    tick();
    checkOutput("a_write_count", 32'(write_count), 32'd12);
    checkOutput("a_pulse_count", 32'(pulse_count), 32'd1);
    checkOutput("a_busy_after", 32'(frame_busy), 32'd0);
    checkOutput("a_done_cleared", 32'(frame_done), 32'd0);

    // Frame B: new parameters latched; slow engine at (3,0); backpressure at addr 5.
    exp_addr = 0; write_count = 0; pulse_count = 0;
    slow_en = 1'b1;
    applyStimulus(16'h2000, 16'h0100, 8'h07, 6'd31);
    checkOutput("b_center_x_latched", 32'(center_x), 32'h2000);
    n = 0;
    while (!(pixel_valid && pixel_x == 10'd3 && pixel_y == 10'd0) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("b_slow_reached", 32'(pixel_valid && pixel_x == 10'd3), 32'd1);
    for (int i = 0; i < 35; i++) begin
      if (i % 10 == 0) begin
        checkOutput("b_slow_valid", 32'(pixel_valid), 32'd1);
        checkOutput("b_slow_x", 32'(pixel_x), 32'd3);
        checkOutput("b_slow_y", 32'(pixel_y), 32'd0);
        checkOutput("b_slow_no_write", 32'(wr_valid), 32'd0);
      end
      tick();
    end
    n = 0;
    while (!(pixel_valid && pixel_x == 10'd1 && pixel_y == 10'd1) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("b_bp_reached", 32'(pixel_valid && pixel_y == 10'd1), 32'd1);
    wr_ready = 1'b0;
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("b_bp_wr_valid", 32'(wr_valid), 32'd1);
      checkOutput("b_bp_wr_addr", 32'(wr_addr), 32'd5);
      checkOutput("b_bp_wr_data", 32'(wr_data), 32'd3);
      checkOutput("b_bp_pixel_valid", 32'(pixel_valid), 32'd0);
      tick();
    end
    wr_ready = 1'b1;
    n = 0;
    while (!pixel_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("b_next_valid", 32'(pixel_valid), 32'd1);
    checkOutput("b_next_x", 32'(pixel_x), 32'd2);
    checkOutput("b_next_y", 32'(pixel_y), 32'd1);
    waitFrameDone("b_frame_done_seen");
    tick();
    checkOutput("b_write_count", 32'(write_count), 32'd12);
    checkOutput("b_pulse_count", 32'(pulse_count), 32'd1);
    slow_en = 1'b0;

    // Frame C: abort in ISSUE at addr 6, start while engine busy, restart.
    exp_addr = 0; write_count = 0; pulse_count = 0;
    applyStimulus(16'h0ABC, 16'h0123, 8'h02, 6'd15);
    n = 0;
    while (!(pixel_valid && wr_addr == 4'd6) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("c_abort_reached", 32'(pixel_valid && wr_addr == 4'd6), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("c_abort_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("c_abort_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("c_abort_idle", 32'(frame_busy), 32'd0);
    checkOutput("c_abort_no_done", 32'(frame_done), 32'd0);
    checkOutput("c_abort_center_x", 32'(center_x), 32'h0ABC);
    checkOutput("c_eng_busy_pre", 32'(eng_busy), 32'd1);
    applyStimulus(16'h0DEF, 16'h0123, 8'h02, 6'd15);
    checkOutput("c_busy_start_ignored", 32'(frame_busy), 32'd0);
    checkOutput("c_busy_start_no_req", 32'(pixel_valid), 32'd0);
    checkOutput("c_busy_start_center", 32'(center_x), 32'h0ABC);
    n = 0;
    while (eng_busy && n < 30) begin
      tick();
      n++;
    end
    checkOutput("c_eng_idle", 32'(eng_busy), 32'd0);
    checkOutput("c_pulse_none", 32'(pulse_count), 32'd0);
    exp_addr = 0; write_count = 0;
    applyStimulus(16'h0DEF, 16'h0123, 8'h02, 6'd15);
    checkOutput("c_restart_busy", 32'(frame_busy), 32'd1);
    checkOutput("c_restart_addr", 32'(wr_addr), 32'd0);
    checkOutput("c_restart_x", 32'(pixel_x), 32'd0);
    checkOutput("c_restart_y", 32'(pixel_y), 32'd0);
    checkOutput("c_restart_center", 32'(center_x), 32'h0DEF);
    waitFrameDone("c_frame_done_seen");
    tick();
    checkOutput("c_write_count", 32'(write_count), 32'd12);
    checkOutput("c_pulse_count", 32'(pulse_count), 32'd1);

    // Frame D: asynchronous reset mid-frame.
    exp_addr = 0; write_count = 0;
    applyStimulus(16'h1234, 16'h5678, 8'h09, 6'd40);
    repeat (12) tick();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("d_rst_frame_busy", 32'(frame_busy), 32'd0);
    checkOutput("d_rst_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("d_rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("d_rst_center_x", 32'(center_x), 32'd0);
    checkOutput("d_rst_zoom", 32'(zoom_level), 32'd0);
    checkOutput("d_rst_coords", 32'({pixel_x, pixel_y}), 32'd0);
    checkOutput("d_rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("d_rst_wr_data", 32'(wr_data), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Raster sequencer directly upstream of the Mandelbrot engine.
- On a frame start it latches the view parameters and walks every pixel in raster order. For each pixel it runs one request/release handshake with the engine, then writes the returned iteration count to a framebuffer write port.
- The write port supports backpressure.
- One frame is computed per start, with parameters frozen for the whole frame.

Parameters:
- H_RES, 640, pixels per line (x range 0..H_RES-1)
- V_RES, 480, lines per frame (y range 0..V_RES-1)
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_RES*V_RES
- ITER_WIDTH, 6, iteration count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame start request (level sampled)
- abort  in  1  synchronous frame abort
- center_x_in  in  16  signed view center X, sampled at start
- center_y_in  in  16  signed view center Y, sampled at start
- zoom_in  in  8  zoom level, sampled at start
- max_iter_in  in  ITER_WIDTH  iteration limit, sampled at start
- center_x  out  16  latched center X to engine
- center_y  out  16  latched center Y to engine
- zoom_level  out  8  latched zoom to engine
- max_iter_limit  out  ITER_WIDTH  latched limit to engine
- pixel_x  out  10  current pixel X to engine
- pixel_y  out  10  current pixel Y to engine
- pixel_valid  out  1  request to engine
- eng_result_valid  in  1  engine result ready
- eng_iteration_count  in  ITER_WIDTH  engine result
- eng_busy  in  1  engine not idle
- wr_valid  out  1  framebuffer write request
- wr_addr  out  ADDR_WIDTH  linear address y*H_RES+x
- wr_data  out  ITER_WIDTH  iteration count
- wr_ready  in  1  framebuffer accepts write
- frame_busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse, last pixel written

Behaviour:
- Reset: all outputs 0; state IDLE; x, y and address counters 0.
- All outputs are registered except frame_busy, which is decoded from the state.
- States: IDLE, ISSUE, RELEASE, WRITE.
- IDLE, entry to ISSUE:
  - Requires start=1 && eng_busy=0 && abort=0.
  - On entry: latch all four *_in to the outputs; x=y=addr=0; pixel_valid<=1; go ISSUE.
  - start while eng_busy=1 is ignored, not queued.
- ISSUE:
  - pixel_valid=1; pixel_x, pixel_y held constant.
  - When eng_result_valid=1 is sampled: wr_data<=eng_iteration_count; pixel_valid<=0; go RELEASE.
  - No timeout.
- RELEASE:
  - Wait for eng_busy=0.
  - Then wr_valid<=1, with wr_addr and wr_data stable; go WRITE.
- WRITE:
  - Hold wr_valid, wr_addr and wr_data until wr_valid && wr_ready.
  - On the handshake: wr_valid<=0.
  - If x==H_RES-1 && y==V_RES-1: frame_done<=1 for one cycle; go IDLE.
  - Otherwise advance, then pixel_valid<=1 and go ISSUE:
    - x==H_RES-1: x<=0, y<=y+1.
    - else: x<=x+1.
    - addr<=addr+1 in both cases.
- Address is an incrementing counter; no multiplier.
- wr_addr always equals y*H_RES+x of the written pixel.
- Exactly one write per pixel; never more than one outstanding engine request.
- Latched parameter outputs change only on frame start.
- start during frame_busy=1 is ignored.
- abort=1 in any state (priority over start and all handshakes):
  - Next cycle: pixel_valid=0, wr_valid=0, frame_done=0, state IDLE.
  - Any pending write is dropped.
  - Latched parameters are retained.
  - Restart requires eng_busy=0.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Test Plan:
Bench setup: H_RES=4, V_RES=3, behavioural engine model that honours the handshake.
- Reset: assert rst_n=0 mid-frame -> all outputs 0 asynchronously, frame_busy=0.
- Full frame:
  - Stimulus: model returns (x+2y)%64 with a 3-cycle latency, wr_ready=1.
  - Required: 12 writes, addr 0..11 in order, correct data; one frame_done pulse in the cycle after addr 11 is accepted; frame_busy=0 after.
- Backpressure:
  - Stimulus: wr_ready=0 for 5 cycles at addr 5.
  - Required: wr_valid, wr_addr=5 and wr_data stable throughout; pixel_valid stays 0 until accepted; next request is pixel (2,1).
- Slow engine:
  - Stimulus: result delayed 40 cycles at pixel (3,0).
  - Required: pixel_valid held high with x=3, y=0 stable; then a single write at addr 3.
- Parameter latch:
  - Stimulus: center_x_in changes 0x1000->0x2000 mid frame.
  - Required: center_x stays 0x1000 until frame_done; the next start latches 0x2000.
- Abort and restart:
  - Stimulus: abort in ISSUE at addr 6.
  - Required: next cycle pixel_valid=0, IDLE, no frame_done.
  - Stimulus: start while eng_busy=1.
  - Required: ignored.
  - Stimulus: start after eng_busy=0.
  - Required: restarts at addr 0.
